fp_mul_issuer: RTL
==================

Name: fp_mul_issuer

Overview:
Initiator-side controller for the 32-bit FP multiplier's start/done handshake. Buffers incoming operand pairs in a small FIFO and issues them one at a time to the multiplier. Waits for done and returns product plus exception flags on a valid/ready result port. Sits between a host/DMA operand source and multiplier32FP, replacing bench-driven stimulus in the integrated datapath.

Parameters:
OP_DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 64, cycles in WAIT without mul_done_i before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op_valid_i  in  1  operand pair offered
op_ready_o  out  1  FIFO not full
op_a_i  in  32  IEEE-754 single operand A
op_b_i  in  32  IEEE-754 single operand B
mul_start_o  out  1  one-cycle start pulse to multiplier
mul_a_o  out  32  operand A to multiplier, stable from start until done
mul_b_o  out  32  operand B to multiplier, stable from start until done
mul_done_i  in  1  multiplier completion pulse; result valid this cycle
mul_product_i  in  32  multiplier product
mul_flags_i  in  4  {nan, infinit, overflow, underflow} from multiplier
res_valid_o  out  1  result held
res_ready_i  in  1  result consumer ready
res_product_o  out  32  captured product
res_flags_o  out  5  {timeout, nan, infinit, overflow, underflow}
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0 except op_ready_o=1; mul_a_o/mul_b_o=0.
- Operand push: accepted when op_valid_i & op_ready_o. Pointer width log2(OP_DEPTH)+1; full when pointer MSBs differ and lower bits are equal. Simultaneous push and pop is allowed when full: pop frees the slot next cycle only, so op_ready_o stays 0 that cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into mul_a_o/mul_b_o, go to ISSUE.
  - ISSUE: mul_start_o=1 for exactly this cycle, clear the timeout counter, go to WAIT.
  - WAIT: mul_done_i=1 -> capture product and flags into the result register, go to HOLD. Counter reaches TIMEOUT_CYCLES-1 without done -> product=32'h7FC00000, flags=5'b1_0000, go to HOLD. A done arriving in any other state is ignored.
  - HOLD: res_valid_o=1. On res_ready_i go to IDLE; if the FIFO is non-empty, pop in the same cycle and go directly to ISSUE.
- Latency: push in cycle N -> earliest mul_start_o in N+2 (empty FIFO, IDLE). Done in cycle M -> res_valid_o in M+1. Back-to-back issue gap: res handshake cycle -> start next cycle.
- res_product_o/res_flags_o hold stable while res_valid_o=1 and res_ready_i=0.
- Only one operation is in flight; mul_a_o/mul_b_o never change between start and done or timeout.
- Reset mid-operation: everything clears immediately; FIFO contents are discarded; any later stray mul_done_i is ignored (FSM is in IDLE).

Optional Feature:
FP_MUL_ISSUER_STATS_EN
- Defined: adds output ports stat_ops_o[31:0] (completed results handed off) and stat_exc_o[31:0] (handed-off results with any flag bit set). Both are saturating, cleared by rst, and increment on the res handshake.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fp_mul_pkg holds:
  - issuer_state_e enum (IDLE, ISSUE, WAIT, HOLD)
  - flag bit index constants (FLG_UNF=0, FLG_OVF=1, FLG_INF=2, FLG_NAN=3, FLG_TMO=4)
  - QNAN_CONST = 32'h7FC00000
- One sub-module: fp_op_fifo (parameterised sync FIFO, 64-bit entries, async active-high reset), instantiated once.

Test Plan:
- Push 3.0 (40400000) x 2.0 (40000000), res_ready_i=1, mock multiplier done 5 cycles after start -> one mul_start_o pulse; res_product_o=40C00000 and flags=0 one cycle after done.
- Push OP_DEPTH+1 pairs back-to-back with multiplier stalled -> op_ready_o drops once the FIFO holds OP_DEPTH entries. After all dones, results emerge in push order with no loss or duplication.
- Mock returns done with flags=4'b1000 for 7F800000 x 00000000 -> res_flags_o=5'b0_1000 and the product is passed through unchanged.
- Mock never asserts done, TIMEOUT_CYCLES=8 -> res_valid_o 8 cycles after start, product=7FC00000, flags=5'b1_0000. A late done is ignored and the next operand is issued normally.
- Hold res_ready_i=0 for 10 cycles with 2 pairs queued -> result held stable and no second start. Release -> second start exactly one cycle after the handshake.
- Assert rst while in WAIT with 2 pairs queued -> outputs return to reset values asynchronously; after release busy_o=0 and no mul_start_o.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and constants for the FP multiplier issuer:
//   issuer_state_e : issue FSM states
//   FLG_*          : bit positions inside the 5-bit result flag vector
//                    {timeout, nan, infinit, overflow, underflow}
//   QNAN_CONST     : product reported when an operation times out
// -----------------------------------------------------------------------------
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issuer_state_e;

    localparam int FLG_UNF = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_INF = 2;
    localparam int FLG_NAN = 3;
    localparam int FLG_TMO = 4;

    localparam logic [31:0] QNAN_CONST = 32'h7FC0_0000;

endpackage : fp_mul_pkg

// File: rtl/fp_op_fifo.sv
// -----------------------------------------------------------------------------
// fp_op_fifo
// Synchronous first-word-fall-through FIFO holding operand pairs {a, b}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset (empties the FIFO)
//   push_i   in  write wdata_i (ignored when full)
//   wdata_i  in  entry to write
//   pop_i    in  discard the head entry (ignored when empty)
//   rdata_o  out head entry, valid whenever empty_o=0
//   full_o   out DEPTH entries held
//   empty_o  out no entries held
// -----------------------------------------------------------------------------
module fp_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come from registered pointers, so a pop while full only
    // frees the slot for a push on the following cycle.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // meaningful, and leaving the array unreset keeps it plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule : fp_op_fifo

// File: rtl/fp_mul_issuer.sv
// -----------------------------------------------------------------------------
// fp_mul_issuer
// Initiator for the 32-bit FP multiplier start/done handshake. Operand pairs
// are buffered in fp_op_fifo and issued one at a time; the product and
// flags are returned on a valid/ready result port. A multiplier that never
// answers is aborted after TIMEOUT_CYCLES with a quiet NaN and the timeout
// flag.
//   clk, rst                      clock / async active-high reset
//   op_valid_i, op_ready_o        operand push handshake
//   op_a_i, op_b_i                IEEE-754 single operands
//   mul_start_o                   one-cycle start pulse to the multiplier
//   mul_a_o, mul_b_o              operands, stable from start until done
//   mul_done_i                    completion pulse (product valid this cycle)
//   mul_product_i, mul_flags_i    product and {nan, inf, ovf, unf}
//   res_valid_o, res_ready_i      result handshake
//   res_product_o, res_flags_o    product and {timeout, nan, inf, ovf, unf}
//   busy_o                        FIFO non-empty or FSM not IDLE
// Optional build macro FP_MUL_ISSUER_STATS_EN adds saturating counters:
//   stat_ops_o                    results handed off
//   stat_exc_o                    handed-off results with any flag set
// -----------------------------------------------------------------------------
module fp_mul_issuer
    import fp_mul_pkg::*;
#(
    parameter int OP_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic        mul_done_i,
    input  logic [31:0] mul_product_i,
    input  logic [3:0]  mul_flags_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_product_o,
    output logic [4:0]  res_flags_o,
`ifdef FP_MUL_ISSUER_STATS_EN
    output logic [31:0] stat_ops_o,
    output logic [31:0] stat_exc_o,
`endif
    output logic        busy_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The counter is cleared in ISSUE and advances once per WAIT cycle; the
    // abort fires on the WAIT cycle where it would step to TIMEOUT_CYCLES-1,
    // so the result appears TIMEOUT_CYCLES cycles after the start pulse.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    issuer_state_e state_q, state_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [31:0]   prod_q, prod_d;
    logic [4:0]    flg_q, flg_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_rdata;

    assign fifo_push = op_valid_i && op_ready_o;

    fp_op_fifo #(
        .DEPTH (OP_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({op_a_i, op_b_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            flg_q   <= flg_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        flg_d    = flg_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = fifo_rdata[63:32];
                    b_d      = fifo_rdata[31:0];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done on the abort cycle still wins over the timeout.
                if (mul_done_i) begin
                    prod_d  = mul_product_i;
                    flg_d   = {1'b0, mul_flags_i};
                    state_d = HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    prod_d         = QNAN_CONST;
                    flg_d          = '0;
                    flg_d[FLG_TMO] = 1'b1;
                    state_d        = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        a_d      = fifo_rdata[63:32];
                        b_d      = fifo_rdata[31:0];
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_ready_o    = !fifo_full;
    assign mul_start_o   = (state_q == ISSUE);
    assign mul_a_o       = a_q;
    assign mul_b_o       = b_q;
    assign res_valid_o   = (state_q == HOLD);
    assign res_product_o = prod_q;
    assign res_flags_o   = flg_q;
    assign busy_o        = !fifo_empty || (state_q != IDLE);

`ifdef FP_MUL_ISSUER_STATS_EN
    logic        res_hs;
    logic [31:0] stat_ops_q;
    logic [31:0] stat_exc_q;

    assign res_hs = res_valid_o && res_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_exc_q <= '0;
        end else if (res_hs) begin
            if (stat_ops_q != '1)               stat_ops_q <= stat_ops_q + 1'b1;
            if ((|flg_q) && (stat_exc_q != '1)) stat_exc_q <= stat_exc_q + 1'b1;
        end
    end

    assign stat_ops_o = stat_ops_q;
    assign stat_exc_o = stat_exc_q;
`endif

endmodule : fp_mul_issuer
